key_entry_ctrl: RTL and testbench

//  Keypad-side producer of the 4-digit key buffer that the LCD display drivers consume.

---
 rtl/alarm_clock_pkg.sv | 33 +++
 rtl/key_timeout_timer.sv | 37 +++
 rtl/key_entry_ctrl.sv | 167 ++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared constants, state encoding and time range check for the keypad entry path.
package alarm_clock_pkg;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_BKSP   = 4'hB;
    localparam logic [3:0] MAX_DIGIT  = 4'd9;
    localparam logic [3:0] MAX_MS_HR  = 4'd2;
    localparam logic [7:0] MAX_HR     = 8'd23;
    localparam logic [3:0] MAX_MS_MIN = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2,
        ST_ERROR = 2'd3
    } key_state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= MAX_DIGIT);
    endfunction

    // HH:MM in BCD digits; hours are checked as a full decimal value, not per digit.
    function automatic logic time_is_valid(input logic [3:0] ms_hr,
                                           input logic [3:0] ls_hr,
                                           input logic [3:0] ms_min,
                                           input logic [3:0] ls_min);
        logic [7:0] hours;
        hours = ({4'd0, ms_hr} * 8'd10) + {4'd0, ls_hr};
        return (ms_hr <= MAX_MS_HR) && (hours <= MAX_HR) && (ls_hr <= MAX_DIGIT) &&
               (ms_min <= MAX_MS_MIN) && (ls_min <= MAX_DIGIT);
    endfunction

endpackage

// File: rtl/key_timeout_timer.sv
// Idle timeout: down-counter of one_second ticks, reloaded on clear or while disabled,
// with a combinational expire pulse on the terminal tick.
module key_timeout_timer #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tick,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_SEC + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_SEC);

    logic [CW-1:0] remain;
    logic          terminal;

    assign terminal = (remain <= CW'(1));
    // A clear in the same cycle as the final tick suppresses the expiry.
    assign expire   = enable && !clear && tick && terminal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remain <= '0;
        end else if (clear || !enable) begin
            remain <= LOAD_VAL;
        end else if (tick) begin
            if (terminal)
                remain <= LOAD_VAL;
            else
                remain <= remain - CW'(1);
        end
    end

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: shifts digits into HH:MM, range-checks and strobes alarm/time loads.
// Optional KEY_ENTRY_BACKSPACE_EN enables the backspace key in ENTRY/FULL.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | no entry in progress, buffer zero, display shows normal time
//  ST_ENTRY | 1-3 digits entered
//  ST_FULL  | 4 digits entered, waiting for a commit button (or commit pending)
//  ST_ERROR | commit of an out-of-range time, buffer held until any key
module key_entry_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic [3:0] key_ms_hr,
    output logic [3:0] key_ls_hr,
    output logic [3:0] key_ms_min,
    output logic [3:0] key_ls_min,
    output logic       show_new_time,
    output logic       load_alarm,
    output logic       load_new_time,
    output logic       entry_error
);

    key_state_e state;
    logic [2:0] count;
    logic       commit_pend;
    logic       timer_en;
    logic       timer_expire;
    logic       buf_valid;
    logic       key_digit;
    logic       any_button;

    assign timer_en   = (state != ST_IDLE);
    assign buf_valid  = time_is_valid(key_ms_hr, key_ls_hr, key_ms_min, key_ls_min);
    assign key_digit  = is_digit(key);
    assign any_button = alarm_button || time_button;

    key_timeout_timer #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (one_second),
        .enable  (timer_en),
        .clear   (key_valid),
        .expire  (timer_expire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            count         <= 3'd0;
            commit_pend   <= 1'b0;
            key_ms_hr     <= 4'd0;
            key_ls_hr     <= 4'd0;
            key_ms_min    <= 4'd0;
            key_ls_min    <= 4'd0;
            show_new_time <= 1'b0;
            load_alarm    <= 1'b0;
            load_new_time <= 1'b0;
            entry_error   <= 1'b0;
        end else begin
            load_alarm    <= 1'b0;
            load_new_time <= 1'b0;
            if (commit_pend) begin
                // Strobe cycle is over; the consumer has latched the buffer.
                commit_pend   <= 1'b0;
                state         <= ST_IDLE;
                count         <= 3'd0;
                key_ms_hr     <= 4'd0;
                key_ls_hr     <= 4'd0;
                key_ms_min    <= 4'd0;
                key_ls_min    <= 4'd0;
                show_new_time <= 1'b0;
            end else if (state == ST_FULL && any_button) begin
                if (buf_valid) begin
                    load_alarm    <= alarm_button;
                    load_new_time <= !alarm_button;
                    commit_pend   <= 1'b1;
                end else begin
                    state       <= ST_ERROR;
                    entry_error <= 1'b1;
                end
            end else if (key_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (key_digit) begin
                            key_ms_hr     <= key_ls_hr;
                            key_ls_hr     <= key_ms_min;
                            key_ms_min    <= key_ls_min;
                            key_ls_min    <= key;
                            count         <= 3'd1;
                            state         <= ST_ENTRY;
                            show_new_time <= 1'b1;
                        end
                    end
                    ST_ENTRY, ST_FULL: begin
                        if (key == KEY_CLEAR) begin
                            state         <= ST_IDLE;
                            count         <= 3'd0;
                            key_ms_hr     <= 4'd0;
                            key_ls_hr     <= 4'd0;
                            key_ms_min    <= 4'd0;
                            key_ls_min    <= 4'd0;
                            show_new_time <= 1'b0;
                        end else if (key_digit && count < 3'd4) begin
                            key_ms_hr  <= key_ls_hr;
                            key_ls_hr  <= key_ms_min;
                            key_ms_min <= key_ls_min;
                            key_ls_min <= key;
                            count      <= count + 3'd1;
                            state      <= (count == 3'd3) ? ST_FULL : ST_ENTRY;
`ifdef KEY_ENTRY_BACKSPACE_EN
                        end else if (key == KEY_BKSP) begin
                            key_ms_hr  <= 4'd0;
                            key_ls_hr  <= key_ms_hr;
                            key_ms_min <= key_ls_hr;
                            key_ls_min <= key_ms_min;
                            count      <= count - 3'd1;
                            if (count == 3'd1) begin
                                state         <= ST_IDLE;
                                show_new_time <= 1'b0;
                            end else begin
                                state <= ST_ENTRY;
                            end
`endif
                        end
                    end
                    default: begin
                        // ST_ERROR: any key abandons the bad entry; a digit starts a new one.
                        entry_error <= 1'b0;
                        key_ms_hr   <= 4'd0;
                        key_ls_hr   <= 4'd0;
                        key_ms_min  <= 4'd0;
                        if (key_digit) begin
                            key_ls_min    <= key;
                            count         <= 3'd1;
                            state         <= ST_ENTRY;
                            show_new_time <= 1'b1;
                        end else begin
                            key_ls_min    <= 4'd0;
                            count         <= 3'd0;
                            state         <= ST_IDLE;
                            show_new_time <= 1'b0;
                        end
                    end
                endcase
            end else if (timer_expire) begin
                state         <= ST_IDLE;
                count         <= 3'd0;
                key_ms_hr     <= 4'd0;
                key_ls_hr     <= 4'd0;
                key_ms_min    <= 4'd0;
                key_ls_min    <= 4'd0;
                show_new_time <= 1'b0;
                entry_error   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Vector-table bench for key_entry_ctrl with an expected-result queue, plus an async reset sequence.
module tb_key_entry_ctrl;

    logic       clock;
    logic       reset_n;
    logic       one_second;
    logic [3:0] key;
    logic       key_valid;
    logic       alarm_button;
    logic       time_button;
    logic [3:0] key_ms_hr;
    logic [3:0] key_ls_hr;
    logic [3:0] key_ms_min;
    logic [3:0] key_ls_min;
    logic       show_new_time;
    logic       load_alarm;
    logic       load_new_time;
    logic       entry_error;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        kv;
        logic [3:0]  key;
        logic        ab;
        logic        tb;
        logic        tick;
        logic [15:0] exp_digits;
        logic        exp_show;
        logic        exp_la;
        logic        exp_lt;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    key_entry_ctrl #(.TIMEOUT_SEC(10)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .one_second    (one_second),
        .key           (key),
        .key_valid     (key_valid),
        .alarm_button  (alarm_button),
        .time_button   (time_button),
        .key_ms_hr     (key_ms_hr),
        .key_ls_hr     (key_ls_hr),
        .key_ms_min    (key_ms_min),
        .key_ls_min    (key_ls_min),
        .show_new_time (show_new_time),
        .load_alarm    (load_alarm),
        .load_new_time (load_new_time),
        .entry_error   (entry_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endtask

    task automatic add(input logic kv, input logic [3:0] k, input logic ab, input logic tb,
                       input logic tick, input logic [15:0] e, input logic show,
                       input logic la, input logic lt, input logic err, input string n);
        vec_t v;
        v.kv = kv; v.key = k; v.ab = ab; v.tb = tb; v.tick = tick;
        v.exp_digits = e; v.exp_show = show; v.exp_la = la; v.exp_lt = lt; v.exp_err = err;
        v.name = n;
        vecs.push_back(v);
    endtask

    task automatic dig(input logic [3:0] k, input logic [15:0] e, input logic show,
                       input logic err, input string n);
        add(1'b1, k, 1'b0, 1'b0, 1'b0, e, show, 1'b0, 1'b0, err, n);
    endtask

    task automatic tck(input logic [15:0] e, input logic show, input string n);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, e, show, 1'b0, 1'b0, 1'b0, n);
    endtask

    task automatic idl(input logic [15:0] e, input logic show, input logic err, input string n);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, e, show, 1'b0, 1'b0, err, n);
    endtask

    task automatic drive_idle();
        key_valid = 1'b0; key = 4'h0; alarm_button = 1'b0;
        time_button = 1'b0; one_second = 1'b0;
    endtask

    function automatic logic [15:0] digits();
        return {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
    endfunction

    initial begin
        vec_t e;
        reset_n = 1'b0;
        drive_idle();

        // t1: valid alarm commit
        dig(4'd1, 16'h0001, 1, 0, "t1_k1");
        dig(4'd2, 16'h0012, 1, 0, "t1_k2");
        dig(4'd3, 16'h0123, 1, 0, "t1_k3");
        dig(4'd4, 16'h1234, 1, 0, "t1_k4");
        add(0, 4'h0, 1, 0, 0, 16'h1234, 1, 1, 0, 0, "t1_alarm");
        idl(16'h0000, 0, 0, "t1_clear");
        idl(16'h0000, 0, 0, "t1_idle");
        // t2: out-of-range hours, error recovery with a digit
        dig(4'd2, 16'h0002, 1, 0, "t2_k2");
        dig(4'd5, 16'h0025, 1, 0, "t2_k5");
        dig(4'd0, 16'h0250, 1, 0, "t2_k0a");
        dig(4'd0, 16'h2500, 1, 0, "t2_k0b");
        add(0, 4'h0, 0, 1, 0, 16'h2500, 1, 0, 0, 1, "t2_time_bad");
        idl(16'h2500, 1, 1, "t2_err_hold");
        dig(4'd7, 16'h0007, 1, 0, "t2_k7");
        dig(4'd1, 16'h0071, 1, 0, "t2_k1");
        dig(4'd2, 16'h0712, 1, 0, "t2_k2b");
        dig(4'd3, 16'h7123, 1, 0, "t2_k3");
        dig(4'd5, 16'h7123, 1, 0, "t2_full_drop");
        dig(4'hA, 16'h0000, 0, 0, "t2_clear");
        // t3: idle timeout, and a key on the final tick restarting the timer
        dig(4'd0, 16'h0000, 1, 0, "t3_k0");
        dig(4'd9, 16'h0009, 1, 0, "t3_k9");
        for (int i = 1; i <= 9; i++) tck(16'h0009, 1, "t3_tick");
        tck(16'h0000, 0, "t3_timeout");
        dig(4'd0, 16'h0000, 1, 0, "t3b_k0");
        dig(4'd9, 16'h0009, 1, 0, "t3b_k9");
        for (int i = 1; i <= 9; i++) tck(16'h0009, 1, "t3b_tick");
        add(1, 4'd1, 0, 0, 1, 16'h0091, 1, 0, 0, 0, "t3b_key_on_tick10");
        for (int i = 1; i <= 9; i++) tck(16'h0091, 1, "t3b_tick_restart");
        tck(16'h0000, 0, "t3b_timeout");
        // t4: overflow digit dropped, CLEAR, CLEAR in IDLE
        dig(4'd1, 16'h0001, 1, 0, "t4_k1");
        dig(4'd2, 16'h0012, 1, 0, "t4_k2");
        dig(4'd3, 16'h0123, 1, 0, "t4_k3");
        dig(4'd4, 16'h1234, 1, 0, "t4_k4");
        dig(4'd5, 16'h1234, 1, 0, "t4_k5_drop");
        dig(4'hA, 16'h0000, 0, 0, "t4_clear");
        dig(4'hA, 16'h0000, 0, 0, "t4_clear_idle");
        // t5: both buttons plus a key in one cycle
        dig(4'd0, 16'h0000, 1, 0, "t5_k0");
        dig(4'd8, 16'h0008, 1, 0, "t5_k8");
        dig(4'd3, 16'h0083, 1, 0, "t5_k3");
        dig(4'd0, 16'h0830, 1, 0, "t5_k0b");
        add(1, 4'd9, 1, 1, 0, 16'h0830, 1, 1, 0, 0, "t5_all_at_once");
        idl(16'h0000, 0, 0, "t5_clear");
        // boundaries: 23:59 accepted, 24:00 and 19:60 rejected, non-digit clears ERROR
        dig(4'd2, 16'h0002, 1, 0, "b_k2");
        dig(4'd3, 16'h0023, 1, 0, "b_k3");
        dig(4'd5, 16'h0235, 1, 0, "b_k5");
        dig(4'd9, 16'h2359, 1, 0, "b_k9");
        add(0, 4'h0, 0, 1, 0, 16'h2359, 1, 0, 1, 0, "b_time_2359");
        idl(16'h0000, 0, 0, "b_clear_2359");
        dig(4'd2, 16'h0002, 1, 0, "b24_k2");
        dig(4'd4, 16'h0024, 1, 0, "b24_k4");
        dig(4'd0, 16'h0240, 1, 0, "b24_k0");
        dig(4'd0, 16'h2400, 1, 0, "b24_k0b");
        add(0, 4'h0, 1, 0, 0, 16'h2400, 1, 0, 0, 1, "b24_alarm_bad");
        dig(4'hC, 16'h0000, 0, 0, "b24_nondigit_clears");
        dig(4'd1, 16'h0001, 1, 0, "b60_k1");
        dig(4'd9, 16'h0019, 1, 0, "b60_k9");
        dig(4'd6, 16'h0196, 1, 0, "b60_k6");
        dig(4'd0, 16'h1960, 1, 0, "b60_k0");
        add(0, 4'h0, 1, 0, 0, 16'h1960, 1, 0, 0, 1, "b60_alarm_bad");
        dig(4'hA, 16'h0000, 0, 0, "b60_clear");
        // button in ENTRY is ignored
        dig(4'd1, 16'h0001, 1, 0, "e_k1");
        add(0, 4'h0, 1, 0, 0, 16'h0001, 1, 0, 0, 0, "e_alarm_ignored");
        dig(4'hA, 16'h0000, 0, 0, "e_clear");
        // t6: backspace
`ifdef KEY_ENTRY_BACKSPACE_EN
        dig(4'd1, 16'h0001, 1, 0, "t6_k1");
        dig(4'd2, 16'h0012, 1, 0, "t6_k2");
        dig(4'hB, 16'h0001, 1, 0, "t6_bksp1");
        dig(4'hB, 16'h0000, 0, 0, "t6_bksp_idle");
        dig(4'd1, 16'h0001, 1, 0, "t6f_k1");
        dig(4'd2, 16'h0012, 1, 0, "t6f_k2");
        dig(4'd3, 16'h0123, 1, 0, "t6f_k3");
        dig(4'd4, 16'h1234, 1, 0, "t6f_k4");
        dig(4'hB, 16'h0123, 1, 0, "t6f_bksp");
        dig(4'd9, 16'h1239, 1, 0, "t6f_k9");
        dig(4'hA, 16'h0000, 0, 0, "t6f_clear");
`else
        dig(4'd1, 16'h0001, 1, 0, "t6_k1");
        dig(4'd2, 16'h0012, 1, 0, "t6_k2");
        for (int i = 1; i <= 9; i++) tck(16'h0012, 1, "t6_tick");
        dig(4'hB, 16'h0012, 1, 0, "t6_bksp_ignored");
        for (int i = 1; i <= 9; i++) tck(16'h0012, 1, "t6_tick_restart");
        tck(16'h0000, 0, "t6_timeout");
`endif

        // reset state
        #12;
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_flags", {12'd0, show_new_time, load_alarm, load_new_time, entry_error}, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            key_valid    = vecs[i].kv;
            key          = vecs[i].key;
            alarm_button = vecs[i].ab;
            time_button  = vecs[i].tb;
            one_second   = vecs[i].tick;
            sb.push_back(vecs[i]);
            @(posedge clock);
            #1;
            drive_idle();
            e = sb.pop_front();
            chk({e.name, "_digits"}, digits(), e.exp_digits);
            chk({e.name, "_show"}, {15'd0, show_new_time}, {15'd0, e.exp_show});
            chk({e.name, "_load_alarm"}, {15'd0, load_alarm}, {15'd0, e.exp_la});
            chk({e.name, "_load_time"}, {15'd0, load_new_time}, {15'd0, e.exp_lt});
            chk({e.name, "_error"}, {15'd0, entry_error}, {15'd0, e.exp_err});
        end

        // async reset during a full valid entry with a button pending
        for (int d = 1; d <= 4; d++) begin
            @(negedge clock);
            key_valid = 1'b1;
            key = 4'(d);
            @(posedge clock);
            #1;
            drive_idle();
        end
        chk("ar_full", digits(), 16'h1234);
        @(negedge clock);
        alarm_button = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("ar_digits_now", digits(), 16'h0000);
        chk("ar_show_now", {15'd0, show_new_time}, 16'h0000);
        @(posedge clock);
        #1;
        chk("ar_no_strobe", {14'd0, load_alarm, load_new_time}, 16'h0000);
        @(negedge clock);
        drive_idle();
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("ar_after_digits", digits(), 16'h0000);
        chk("ar_after_flags", {12'd0, show_new_time, load_alarm, load_new_time, entry_error}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
